irq_controller: RTL

Machine-level interrupt source that drives the interrupt side of the trap handler (`irq_en`, `irq_code`, `irq_val`). It owns:
- a 64-bit `mtime`/`mtimecmp` timer;
- a software-interrupt bit `msip`;
- `N_EXT` edge-triggered external lines.

It arbitrates among them using the CSR file's `mie` and `mstatus.MIE`, and holds one request until the trap handler takes it. It then blocks further requests until `mret` completes.

---
 rtl/irq_pkg.sv | 19 +
 rtl/irq_ext_pending.sv | 75 +++++++
 rtl/irq_controller.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - cause codes, register map and FSM states for irq_controller
package irq_pkg;

  localparam logic [3:0] IRQ_MEI = 4'd11;
  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;

  localparam logic [1:0] REG_MSIP     = 2'd0;
  localparam logic [1:0] REG_MTIMECMP = 2'd1;
  localparam logic [1:0] REG_MTIME    = 2'd2;
  localparam logic [1:0] REG_EXT_PEND = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_IN_TRAP = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_ext_pending.sv
// rtl/irq_ext_pending.sv - external line edge capture, pending bits, lowest-index pick (IRQ_EXT_SYNC_EN adds a 2-flop synchronizer)
module irq_ext_pending #(
  parameter int N_EXT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_EXT-1:0] ext_irq_i,
  input  logic             clr_i,
  input  logic [3:0]       clr_idx_i,
  output logic [N_EXT-1:0] pend_o,
  output logic             any_o,
  output logic [3:0]       idx_o
);

  logic [N_EXT-1:0] sampled;
  logic [N_EXT-1:0] prev_q;
  logic [N_EXT-1:0] pend_q;
  logic [N_EXT-1:0] pend_d;
  logic [N_EXT-1:0] rise;
  logic [N_EXT-1:0] clr_mask;

`ifdef IRQ_EXT_SYNC_EN
  logic [N_EXT-1:0] sync1_q;
  logic [N_EXT-1:0] sync2_q;

  // two-flop synchronizer for lines that are asynchronous to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ext_irq_i;
      sync2_q <= sync1_q;
    end
  end

  assign sampled = sync2_q;
`else
  assign sampled = ext_irq_i;
`endif

  assign rise = sampled & ~prev_q;

  // clear the serviced line; a new edge in the same cycle keeps it pending
  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < N_EXT; i++) begin
      clr_mask[i] = clr_i && (clr_idx_i == 4'(i));
    end
    pend_d = (pend_q & ~clr_mask) | rise;
  end

  // edge-detect history and pending bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      pend_q <= '0;
    end else begin
      prev_q <= sampled;
      pend_q <= pend_d;
    end
  end

  // lowest pending index wins
  always_comb begin
    idx_o = '0;
    for (int i = N_EXT - 1; i >= 0; i--) begin
      if (pend_q[i]) idx_o = 4'(i);
    end
  end

  assign pend_o = pend_q;
  assign any_o  = |pend_q;

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - machine timer/software/external interrupt arbiter (IRQ_EXT_SYNC_EN selects synchronized ext lines)
module irq_controller
  import irq_pkg::*;
#(
  parameter int N_EXT    = 4,
  parameter int TICK_DIV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_EXT-1:0] ext_irq,
  input  logic             reg_we,
  input  logic [1:0]       reg_addr,
  input  logic [63:0]      reg_wdata,
  output logic [63:0]      reg_rdata,
  input  logic [63:0]      mie,
  input  logic [63:0]      mstatus_current,
  input  logic [1:0]       priv_lvl,
  input  logic             trap_taken,
  input  logic             trap_done,
  output logic             irq_en,
  output logic [3:0]       irq_code,
  output logic [63:0]      irq_val,
  output logic [63:0]      mip
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [63:0]   mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic          msip_q, msip_d;
  logic [PW-1:0] presc_q, presc_d;
  irq_state_e    state_q, state_d;
  logic          irq_en_q, irq_en_d;
  logic [3:0]    irq_code_q, irq_code_d;
  logic [63:0]   irq_val_q, irq_val_d;

  logic [N_EXT-1:0] ext_pend;
  logic             ext_any;
  logic [3:0]       ext_idx;
  logic             ext_clr;

  logic tick, mtip, gie, elig_mei, elig_msi, elig_mti, any_elig, latched_elig;
  logic [3:0]  win_code;
  logic [63:0] win_val;
  logic        unused_bits;

  assign unused_bits = ^{mie[63:12], mie[10:8], mie[6:4], mie[2:0],
                         mstatus_current[63:4], mstatus_current[2:0]};

  irq_ext_pending #(.N_EXT(N_EXT)) u_ext (
    .clk       (clk),
    .rst_n     (rst_n),
    .ext_irq_i (ext_irq),
    .clr_i     (ext_clr),
    .clr_idx_i (irq_val_q[3:0]),
    .pend_o    (ext_pend),
    .any_o     (ext_any),
    .idx_o     (ext_idx)
  );

  assign tick     = (presc_q == PRESC_MAX);
  assign mtip     = (mtime_q >= mtimecmp_q);
  assign gie      = (priv_lvl != 2'b11) | mstatus_current[3];
  assign elig_mei = ext_any & mie[11] & gie;
  assign elig_msi = msip_q & mie[3] & gie;
  assign elig_mti = mtip & mie[7] & gie;
  assign any_elig = elig_mei | elig_msi | elig_mti;

  // timer prescaler, mtime/mtimecmp/msip; a write to mtime beats the tick
  always_comb begin
    presc_d    = tick ? '0 : presc_q + PW'(1);
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (reg_we) begin
      case (reg_addr)
        REG_MSIP:     msip_d     = reg_wdata[0];
        REG_MTIMECMP: mtimecmp_d = reg_wdata;
        REG_MTIME:    mtime_d    = reg_wdata;
        default:      ;
      endcase
    end
  end

  // fixed priority MEI > MSI > MTI
  always_comb begin
    win_code = IRQ_MTI;
    win_val  = '0;
    if (elig_mei) begin
      win_code = IRQ_MEI;
      win_val  = {60'd0, ext_idx};
    end else if (elig_msi) begin
      win_code = IRQ_MSI;
    end
  end

  // is the source behind the held request still eligible
  always_comb begin
    case (irq_code_q)
      IRQ_MEI: latched_elig = elig_mei;
      IRQ_MSI: latched_elig = elig_msi;
      IRQ_MTI: latched_elig = elig_mti;
      default: latched_elig = 1'b0;
    endcase
  end

  // request FSM: raise, hold until taken (or withdraw), then wait for mret
  always_comb begin
    state_d    = state_q;
    irq_en_d   = irq_en_q;
    irq_code_d = irq_code_q;
    irq_val_d  = irq_val_q;
    ext_clr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_elig) begin
          state_d    = ST_REQ;
          irq_en_d   = 1'b1;
          irq_code_d = win_code;
          irq_val_d  = win_val;
        end
      end
      ST_REQ: begin
        if (trap_taken) begin
          state_d  = ST_IN_TRAP;
          irq_en_d = 1'b0;
          ext_clr  = (irq_code_q == IRQ_MEI);
        end else if (!latched_elig) begin
          state_d  = ST_IDLE;
          irq_en_d = 1'b0;
        end
      end
      ST_IN_TRAP: begin
        irq_en_d = 1'b0;
        if (trap_done) state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        irq_en_d = 1'b0;
      end
    endcase
  end

  // all registered state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      presc_q    <= '0;
      state_q    <= ST_IDLE;
      irq_en_q   <= 1'b0;
      irq_code_q <= '0;
      irq_val_q  <= '0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      presc_q    <= presc_d;
      state_q    <= state_d;
      irq_en_q   <= irq_en_d;
      irq_code_q <= irq_code_d;
      irq_val_q  <= irq_val_d;
    end
  end

  // combinational register read-back and mip view
  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      REG_MSIP:     reg_rdata[0] = msip_q;
      REG_MTIMECMP: reg_rdata = mtimecmp_q;
      REG_MTIME:    reg_rdata = mtime_q;
      default:      reg_rdata[N_EXT-1:0] = ext_pend;
    endcase
    mip     = '0;
    mip[11] = ext_any;
    mip[7]  = mtip;
    mip[3]  = msip_q;
  end

  assign irq_en   = irq_en_q;
  assign irq_code = irq_code_q;
  assign irq_val  = irq_val_q;

endmodule
